// File: rtl/branch_resolve_ctrl_if.sv
// Branch request and fetch-redirect channels between the EX-stage pipeline
// and the branch resolution controller.
//   master : pipeline / fetch side (drives the branch, accepts the redirect)
//   slave  : branch_resolve_ctrl
interface branch_resolve_ctrl_if #(
  parameter int PC_W = 32
);
  // Branch request from EX
  logic            br_valid;
  logic            br_ready;
  logic [2:0]      br_cond;
  logic            br_nullify;
  logic            br_backward;
  logic [PC_W-1:0] br_target;
  logic            flag_z;
  logic            flag_n;
  logic            flag_c;
  logic            flag_v;
  logic            flag_odd;

  // Redirect towards the IF-stage PC mux
  logic            redirect_valid;
  logic            redirect_ready;
  logic [PC_W-1:0] redirect_pc;

  modport master (
    output br_valid, br_cond, br_nullify, br_backward, br_target,
           flag_z, flag_n, flag_c, flag_v, flag_odd, redirect_ready,
    input  br_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  br_valid, br_cond, br_nullify, br_backward, br_target,
           flag_z, flag_n, flag_c, flag_v, flag_odd, redirect_ready,
    output br_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/branch_resolve_ctrl.sv
// Conditional-branch resolution controller (EX stage).
// Accepts one compare-and-branch at a time, evaluates its 3-bit condition
// against the ALU flags sampled at acceptance, pulses resolved/taken and the
// delay-slot nullify, then issues a redirect + IF/ID flush for taken branches.
// ID is held while a branch is in flight.
// Optional feature: define BR_STATS_EN to add saturating taken/not-taken
// counters; otherwise the counter outputs are tied to zero.
module branch_resolve_ctrl #(
  parameter int PC_W   = 32,
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  branch_resolve_ctrl_if.slave bus,
  output logic              flush_if,
  output logic              nullify_ds,
  output logic              hold_id,
  output logic              resolved,
  output logic              taken,
  output logic [STAT_W-1:0] stat_taken,
  output logic [STAT_W-1:0] stat_not_taken
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EVAL  = 2'd1,
    S_ISSUE = 2'd2
  } state_t;

  state_t          state_q, state_d;

  // Registered outputs and their next values
  logic            resolved_q,       resolved_d;
  logic            taken_q,          taken_d;
  logic            nullify_q,        nullify_d;
  logic            flush_q,          flush_d;
  logic            redirect_valid_q, redirect_valid_d;
  logic [PC_W-1:0] redirect_pc_q,    redirect_pc_d;

  logic            accept;
  logic            cond_met;
  logic            redirect_fire;

  assign accept        = (state_q == S_IDLE) && bus.br_valid;
  assign redirect_fire = redirect_valid_q && bus.redirect_ready;

  // Branch condition evaluated on the flags presented in the acceptance cycle;
  // the registered outcome is the only copy of the flags the FSM needs later.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    cond_met = 1'b0;
    unique case (bus.br_cond)
      3'b000: cond_met = 1'b0;
      3'b001: cond_met = bus.flag_z;
      3'b010: cond_met = bus.flag_n ^ bus.flag_v;
      3'b011: cond_met = bus.flag_z | (bus.flag_n ^ bus.flag_v);
      3'b100: cond_met = bus.flag_c;
      3'b101: cond_met = bus.flag_z | bus.flag_c;
      3'b110: cond_met = bus.flag_v;
      3'b111: cond_met = bus.flag_odd;
      default: cond_met = 1'b0;
    endcase
  end

  // Next-state and next-output logic for IDLE -> EVAL -> (ISSUE) -> IDLE.
  always_comb begin
    state_d          = state_q;
    resolved_d       = 1'b0;
    nullify_d        = 1'b0;
    flush_d          = 1'b0;
    taken_d          = taken_q;
    redirect_valid_d = redirect_valid_q;
    redirect_pc_d    = redirect_pc_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d       = S_EVAL;
          resolved_d    = 1'b1;
          taken_d       = cond_met;
          // Delay slot is squashed for a taken forward or a not-taken
          // backward branch when the ,n completer is present.
          nullify_d     = bus.br_nullify && (cond_met == !bus.br_backward);
          redirect_pc_d = bus.br_target;
        end
      end
      S_EVAL: begin
        if (taken_q) begin
          state_d          = S_ISSUE;
          redirect_valid_d = 1'b1;
          flush_d          = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (redirect_fire) begin
          state_d          = S_IDLE;
          redirect_valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered-output flops with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state_q          <= S_IDLE;
      resolved_q       <= 1'b0;
      taken_q          <= 1'b0;
      nullify_q        <= 1'b0;
      flush_q          <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      state_q          <= state_d;
      resolved_q       <= resolved_d;
      taken_q          <= taken_d;
      nullify_q        <= nullify_d;
      flush_q          <= flush_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end

  assign bus.br_ready       = (state_q == S_IDLE);
  assign hold_id            = (state_q != S_IDLE) || bus.br_valid;
  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign resolved           = resolved_q;
  assign taken              = taken_q;
  assign nullify_ds         = nullify_q;
  assign flush_if           = flush_q;

`ifdef BR_STATS_EN
  logic [STAT_W-1:0] stat_taken_q;
  logic [STAT_W-1:0] stat_not_taken_q;

  // Saturating outcome counters, bumped in the EVAL cycle of each branch.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_taken_q     <= '0;
      stat_not_taken_q <= '0;
    end else if (state_q == S_EVAL) begin
      if (taken_q) begin
        if (stat_taken_q != '1) stat_taken_q <= stat_taken_q + 1'b1;
      end else begin
        if (stat_not_taken_q != '1) stat_not_taken_q <= stat_not_taken_q + 1'b1;
      end
    end
  end

  assign stat_taken     = stat_taken_q;
  assign stat_not_taken = stat_not_taken_q;
`else
  assign stat_taken     = '0;
  assign stat_not_taken = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Self-checking bench for branch_resolve_ctrl: directed cases plus randomized
// branches checked against a cycle-level reference of the outcome rules.
module tb_branch_resolve_ctrl;
  localparam int PC_W   = 32;
  localparam int STAT_W = 3;
  localparam int STAT_MAX = (1 << STAT_W) - 1;
`ifdef BR_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic flush_if, nullify_ds, hold_id, resolved, taken;
  logic [STAT_W-1:0] stat_taken, stat_not_taken;

  int tests = 0;
  int fails = 0;
  int exp_st = 0;
  int exp_snt = 0;

  branch_resolve_ctrl_if #(.PC_W(PC_W)) bus ();

  branch_resolve_ctrl #(.PC_W(PC_W), .STAT_W(STAT_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus.slave),
    .flush_if       (flush_if),
    .nullify_ds     (nullify_ds),
    .hold_id        (hold_id),
    .resolved       (resolved),
    .taken          (taken),
    .stat_taken     (stat_taken),
    .stat_not_taken (stat_not_taken)
  );

  always #5 clk = ~clk;

  // Outcome of a branch from the condition table; flags = {z,n,c,v,odd}.
  function automatic bit ref_taken(input bit [2:0] cond, input bit [4:0] flags);
    bit z, n, c, v, odd;
    bit outcome [8];
    {z, n, c, v, odd} = flags;
    outcome[0] = 1'b0;
    outcome[1] = z;
    outcome[2] = n != v;
    outcome[3] = z || (n != v);
    outcome[4] = c;
    outcome[5] = z || c;
    outcome[6] = v;
    outcome[7] = odd;
    return outcome[cond];
  endfunction

  // Delay slot dies for forward-taken or backward-not-taken with ,n.
  function automatic bit ref_nullify(input bit nul, input bit back, input bit j);
    if (!nul) return 1'b0;
    return (j && !back) || (!j && back);
  endfunction

  task automatic drive_idle();
    bus.br_valid       = 1'b0;
    bus.br_cond        = 3'b000;
    bus.br_nullify     = 1'b0;
    bus.br_backward    = 1'b0;
    bus.br_target      = '0;
    {bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v, bus.flag_odd} = 5'b0;
    bus.redirect_ready = 1'b0;
  endtask

  task automatic check_stats(input string name);
    int es, en;
    es = STATS ? exp_st : 0;
    en = STATS ? exp_snt : 0;
    tests++;
    if ({int'(stat_taken), int'(stat_not_taken)} !== {es, en}) begin
      fails++;
      $display("FAIL %s stats: got taken=%0d not_taken=%0d, want %0d %0d",
               name, stat_taken, stat_not_taken, es, en);
    end
  endtask

  // Runs one branch from a negedge in IDLE; returns at the negedge where the
  // controller is IDLE again, so calls chain back to back.
  task automatic run_branch(input bit [2:0] cond, input bit [4:0] flags,
                            input bit nul, input bit back,
                            input logic [PC_W-1:0] target, input int stall,
                            input string name);
    bit j, nd;
    j  = ref_taken(cond, flags);
    nd = ref_nullify(nul, back, j);

    tests++;
    if ({bus.br_ready, hold_id, resolved, bus.redirect_valid} !== 4'b1000) begin
      fails++;
      $display("FAIL %s idle: got rdy/hold/res/rv=%b, want 1000", name,
               {bus.br_ready, hold_id, resolved, bus.redirect_valid});
    end

    bus.br_valid    = 1'b1;
    bus.br_cond     = cond;
    bus.br_nullify  = nul;
    bus.br_backward = back;
    bus.br_target   = target;
    {bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v, bus.flag_odd} = flags;
    #1;
    tests++;
    if (hold_id !== 1'b1) begin
      fails++;
      $display("FAIL %s hold_on_valid: got %b, want 1", name, hold_id);
    end

    // T+1: EVAL. Later flag/target changes must not matter.
    @(negedge clk);
    bus.br_valid  = 1'b0;
    bus.br_target = $urandom;
    {bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v, bus.flag_odd} = 5'($urandom);
    bus.br_cond   = 3'($urandom);
    tests++;
    if ({resolved, taken, nullify_ds, bus.br_ready, hold_id, bus.redirect_valid, flush_if}
        !== {1'b1, j, nd, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL %s eval: got res/tk/nul/rdy/hold/rv/fl=%b, want %b", name,
               {resolved, taken, nullify_ds, bus.br_ready, hold_id, bus.redirect_valid, flush_if},
               {1'b1, j, nd, 1'b0, 1'b1, 1'b0, 1'b0});
    end
    if (j) begin
      if (exp_st < STAT_MAX) exp_st++;
    end else begin
      if (exp_snt < STAT_MAX) exp_snt++;
    end

    if (j) begin
      bus.redirect_ready = 1'($urandom);
      for (int s = 0; s <= stall; s++) begin
        @(negedge clk);
        tests++;
        if ({bus.redirect_valid, flush_if, resolved, nullify_ds, bus.br_ready, hold_id}
            !== {1'b1, (s == 0), 1'b0, 1'b0, 1'b0, 1'b1} || bus.redirect_pc !== target) begin
          fails++;
          $display("FAIL %s issue[%0d]: got rv/fl/res/nul/rdy/hold=%b pc=%h, want %b pc=%h",
                   name, s,
                   {bus.redirect_valid, flush_if, resolved, nullify_ds, bus.br_ready, hold_id},
                   bus.redirect_pc, {1'b1, (s == 0), 1'b0, 1'b0, 1'b0, 1'b1}, target);
        end
        bus.redirect_ready = (s == stall);
      end
      @(negedge clk);
      bus.redirect_ready = 1'b0;
      tests++;
      if ({bus.redirect_valid, bus.br_ready, flush_if} !== 3'b010) begin
        fails++;
        $display("FAIL %s post_accept: got rv/rdy/fl=%b, want 010", name,
                 {bus.redirect_valid, bus.br_ready, flush_if});
      end
    end else begin
      @(negedge clk);
      tests++;
      if ({bus.br_ready, bus.redirect_valid, resolved, nullify_ds, flush_if} !== 5'b10000) begin
        fails++;
        $display("FAIL %s not_taken_return: got rdy/rv/res/nul/fl=%b, want 10000", name,
                 {bus.br_ready, bus.redirect_valid, resolved, nullify_ds, flush_if});
      end
    end
    check_stats(name);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive_idle();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    exp_st = 0;
    exp_snt = 0;
    tests++;
    if ({bus.br_ready, hold_id, bus.redirect_valid, flush_if, nullify_ds, resolved, taken}
        !== 7'b1000000 || bus.redirect_pc !== '0) begin
      fails++;
      $display("FAIL reset_values: got rdy/hold/rv/fl/nul/res/tk=%b pc=%h, want 1000000 pc=0",
               {bus.br_ready, hold_id, bus.redirect_valid, flush_if, nullify_ds, resolved, taken},
               bus.redirect_pc);
    end
    check_stats("reset");
  endtask

  task automatic test_directed();
    run_branch(3'b000, 5'b11111, 1'b0, 1'b0, 32'h0000_2000, 0, "never");
    run_branch(3'b001, 5'b10000, 1'b1, 1'b0, 32'h0000_1040, 0, "taken_z_fwd_n");
    run_branch(3'b100, 5'b00000, 1'b1, 1'b1, 32'h0000_0f00, 0, "bwd_nt_nul");
    run_branch(3'b100, 5'b00000, 1'b0, 1'b1, 32'h0000_0f00, 0, "bwd_nt_nonul");
    run_branch(3'b110, 5'b00010, 1'b1, 1'b1, 32'h0000_0800, 1, "bwd_taken_nul");
  endtask

  task automatic test_backpressure();
    run_branch(3'b010, 5'b01000, 1'b0, 1'b0, 32'hdead_bee0, 4, "backpressure");
  endtask

  task automatic test_back_to_back();
    run_branch(3'b101, 5'b00000, 1'b0, 1'b0, 32'h1000_0000, 0, "b2b_nt0");
    run_branch(3'b111, 5'b00000, 1'b1, 1'b0, 32'h1000_0004, 0, "b2b_nt1");
    run_branch(3'b011, 5'b01000, 1'b1, 1'b0, 32'h1000_0008, 0, "b2b_tk");
    run_branch(3'b111, 5'b00001, 1'b0, 1'b1, 32'h1000_000c, 2, "b2b_tk2");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      repeat (gap) @(negedge clk);
      run_branch(3'($urandom), 5'($urandom), 1'($urandom), 1'($urandom),
                 PC_W'($urandom), $urandom_range(0, 3), "random");
    end
  endtask

  task automatic test_reset_in_issue();
    bus.br_valid       = 1'b1;
    bus.br_cond        = 3'b001;
    bus.br_nullify     = 1'b1;
    bus.br_backward    = 1'b0;
    bus.br_target      = 32'h0000_7770;
    {bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v, bus.flag_odd} = 5'b10000;
    bus.redirect_ready = 1'b0;
    @(negedge clk);
    bus.br_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.redirect_valid !== 1'b1) begin
      fails++;
      $display("FAIL rst_issue_entry: got rv=%b, want 1", bus.redirect_valid);
    end
    reset = 1'b1;
    @(negedge clk);
    exp_st = 0;
    exp_snt = 0;
    tests++;
    if ({bus.br_ready, hold_id, bus.redirect_valid, flush_if, nullify_ds, resolved, taken}
        !== 7'b1000000 || bus.redirect_pc !== '0) begin
      fails++;
      $display("FAIL rst_issue_values: got rdy/hold/rv/fl/nul/res/tk=%b pc=%h, want 1000000 pc=0",
               {bus.br_ready, hold_id, bus.redirect_valid, flush_if, nullify_ds, resolved, taken},
               bus.redirect_pc);
    end
    check_stats("rst_issue");
    reset = 1'b0;
    bus.redirect_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tests++;
      if ({bus.redirect_valid, flush_if, bus.br_ready} !== 3'b001) begin
        fails++;
        $display("FAIL rst_issue_quiet[%0d]: got rv/fl/rdy=%b, want 001", k,
                 {bus.redirect_valid, flush_if, bus.br_ready});
      end
    end
    bus.redirect_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_in_issue();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
